// File: rtl/core_mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_mem_arb_pkg : shared encodings for the memory arbiter        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package core_mem_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ARB_IDLE     = 3'd0;
  localparam arb_state_t ARB_IF_BUS   = 3'd1;
  localparam arb_state_t ARB_EX_RD    = 3'd2;
  localparam arb_state_t ARB_EX_MERGE = 3'd3;
  localparam arb_state_t ARB_EX_WR    = 3'd4;
  localparam arb_state_t ARB_RESP     = 3'd5;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

  localparam logic RWInoutR   = 1'b0;
  localparam logic RWInoutW   = 1'b1;
  localparam logic HoldNone   = 1'b0;
  localparam logic HoldEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // States in which a request is presented on the memory port.
  function automatic logic arb_is_bus_state(input arb_state_t s);
    return (s == ARB_IF_BUS) || (s == ARB_EX_RD) || (s == ARB_EX_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_arb_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_mem_arb_timer : loadable down-counter with expiry flag       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module core_mem_arb_timer #(
  parameter int unsigned CNT_W  = 8,
  parameter bit          ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = ENABLE && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/core_mem_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_mem_arb : fetch / EX arbiter and read-merge-write sequencer  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module core_mem_arb
  import core_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              if_flush_in,
  output logic [DATA_W-1:0] if_data_out,
  output logic              if_ready_out,
  input  logic              ex_req_in,
  input  logic              ex_rw_in,
  input  logic [ADDR_W-1:0] ex_addr_in,
  input  logic [DATA_W-1:0] ex_wdata_in,
  output logic [DATA_W-1:0] ex_rdata_out,
  output logic              ex_ready_out,
  output logic              hold_flag_out,
  output logic              bus_err_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ack_in
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD =
    (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  arb_state_t        state_q, state_d;
  logic              served_ex_q, served_ex_d;
  logic              ex_rw_q, ex_rw_d;
  logic              flush_seen_q, flush_seen_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              if_ready_q, if_ready_d;
  logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;
  logic              ex_ready_q, ex_ready_d;

  logic w_bus_state;
  logic w_tmr_expired;
  logic w_abort;
  logic w_grant;

  assign w_bus_state = arb_is_bus_state(state_q);
  assign w_abort     = w_bus_state && !mem_ack_in && w_tmr_expired;
  assign w_grant     = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);

  // Reloaded on every state change, so each bus phase gets a full budget.
  core_mem_arb_timer #(
    .CNT_W  (TMR_W),
    .ENABLE (TIMEOUT_CYCLES != 0)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_d != state_q),
    .load_val_i (TMR_LOAD),
    .dec_i      (w_bus_state && !mem_ack_in),
    .expired_o  (w_tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      served_ex_q  <= 1'b0;
      ex_rw_q      <= RWInoutR;
      flush_seen_q <= 1'b0;
      bus_err_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      if_data_q    <= '0;
      if_ready_q   <= 1'b0;
      ex_rdata_q   <= '0;
      ex_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      served_ex_q  <= served_ex_d;
      ex_rw_q      <= ex_rw_d;
      flush_seen_q <= flush_seen_d;
      bus_err_q    <= bus_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      if_data_q    <= if_data_d;
      if_ready_q   <= if_ready_d;
      ex_rdata_q   <= ex_rdata_d;
      ex_ready_q   <= ex_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (ex_req_in) begin
          state_d = ARB_EX_RD;
        end else if (if_req_in && !if_flush_in) begin
          state_d = ARB_IF_BUS;
        end
      end
      ARB_IF_BUS:   if (mem_ack_in || w_abort) state_d = ARB_RESP;
      ARB_EX_RD: begin
        if (mem_ack_in) begin
          state_d = (ex_rw_q == RWInoutW) ? ARB_EX_MERGE : ARB_RESP;
        end else if (w_abort) begin
          state_d = ARB_RESP;
        end
      end
      ARB_EX_MERGE: state_d = ARB_EX_WR;
      ARB_EX_WR:    if (mem_ack_in || w_abort) state_d = ARB_RESP;
      ARB_RESP:     state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    served_ex_d  = served_ex_q;
    ex_rw_d      = ex_rw_q;
    mem_addr_d   = mem_addr_q;
    flush_seen_d = flush_seen_q;
    if (w_grant) begin
      served_ex_d  = (state_d == ARB_EX_RD);
      ex_rw_d      = (state_d == ARB_EX_RD) ? ex_rw_in : ex_rw_q;
      mem_addr_d   = ((state_d == ARB_EX_RD) ? ex_addr_in : if_addr_in) & ALIGN_MASK;
      flush_seen_d = 1'b0;
    end else if ((state_q == ARB_IF_BUS) && if_flush_in) begin
      flush_seen_d = 1'b1;
    end

    mem_req_d  = arb_is_bus_state(state_d);
    mem_we_d   = (state_d == ARB_EX_WR);
    mem_data_d = (state_q == ARB_EX_MERGE) ? ex_wdata_in : mem_data_q;

    if_data_d = if_data_q;
    if (state_q == ARB_IF_BUS) begin
      if (mem_ack_in)   if_data_d = mem_data_in;
      else if (w_abort) if_data_d = DATA_W'(ZeroWord);
    end
    ex_rdata_d = ex_rdata_q;
    if (state_q == ARB_EX_RD) begin
      if (mem_ack_in)   ex_rdata_d = mem_data_in;
      else if (w_abort) ex_rdata_d = DATA_W'(ZeroWord);
    end

    // A flush on the completing edge also suppresses the fetch pulse.
    ex_ready_d = (state_d == ARB_RESP) && served_ex_q;
    if_ready_d = (state_d == ARB_RESP) && !served_ex_q && !flush_seen_q && !if_flush_in;
    bus_err_d  = bus_err_q | w_abort;
  end

  assign hold_flag_out = (!rst && ex_req_in && !((state_q == ARB_RESP) && served_ex_q))
                         ? HoldEnable : HoldNone;

  assign if_data_out  = if_data_q;
  assign if_ready_out = if_ready_q;
  assign ex_rdata_out = ex_rdata_q;
  assign ex_ready_out = ex_ready_q;
  assign bus_err_out  = bus_err_q;
  assign mem_req_out  = mem_req_q;
  assign mem_we_out   = mem_we_q;
  assign mem_addr_out = mem_addr_q;
  assign mem_data_out = mem_data_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_core_mem_arb : directed vectors and corner sequences           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_core_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic        if_flush_in = 1'b0;
  logic [31:0] if_data_out;
  logic        if_ready_out;
  logic        ex_req_in = 1'b0;
  logic        ex_rw_in = 1'b0;
  logic [31:0] ex_addr_in = '0;
  logic [31:0] ex_wdata_in = '0;
  logic [31:0] ex_rdata_out;
  logic        ex_ready_out;
  logic        hold_flag_out;
  logic        bus_err_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in = '0;
  logic        mem_ack_in = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  int          req_cyc = 0;
  logic [31:0] rd_word = '0;

  always #5 clk = ~clk;

  core_mem_arb #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_in     (if_req_in),
    .if_addr_in    (if_addr_in),
    .if_flush_in   (if_flush_in),
    .if_data_out   (if_data_out),
    .if_ready_out  (if_ready_out),
    .ex_req_in     (ex_req_in),
    .ex_rw_in      (ex_rw_in),
    .ex_addr_in    (ex_addr_in),
    .ex_wdata_in   (ex_wdata_in),
    .ex_rdata_out  (ex_rdata_out),
    .ex_ready_out  (ex_ready_out),
    .hold_flag_out (hold_flag_out),
    .bus_err_out   (bus_err_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_out  (mem_data_out),
    .mem_data_in   (mem_data_in),
    .mem_ack_in    (mem_ack_in)
  );

  // Memory model: acks after ack_delay request cycles (-1 = never), junk data otherwise.
  always @(negedge clk) begin
    if (mem_req_out) begin
      mem_ack_in  = (ack_delay >= 0) && (req_cyc == ack_delay);
      mem_data_in = mem_ack_in ? rd_word : 32'hBAD0_BAD0;
      req_cyc     = req_cyc + 1;
    end else begin
      mem_ack_in  = 1'b0;
      mem_data_in = 32'hBAD0_BAD0;
      req_cyc     = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_ex;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sb_merge(input logic [31:0] w, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[off*8 +: 8] = b;
    return r;
  endfunction

  // Latency counts samples after the request is raised; the IDLE cycle is the first half-cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int          lat = 0;
    int          pulses = 0;
    int          wrong = 0;
    int          wr_cnt = 0;
    bit          hold_ok = 1'b1;
    bit          seen_rd = 1'b0;
    logic [31:0] data = '0;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    rd_word   = v.word;
    ack_delay = v.delay;
    if (v.is_ex) begin
      ex_req_in = 1'b1; ex_rw_in = v.rw; ex_addr_in = v.addr; ex_wdata_in = v.wdata;
    end else begin
      if_req_in = 1'b1; if_addr_in = v.addr;
    end
    for (int n = 1; n <= 16; n++) begin
      sample();
      if (hold_flag_out !== (ex_req_in && (n != v.exp_lat))) hold_ok = 1'b0;
      if (mem_req_out && mem_ack_in) begin
        if (mem_we_out) begin
          wr_cnt++; wr_addr = mem_addr_out; wr_data = mem_data_out;
        end else if (!seen_rd) begin
          seen_rd = 1'b1; rd_addr = mem_addr_out;
        end
      end
      if (v.is_ex ? ex_ready_out : if_ready_out) begin
        pulses++;
        if (lat == 0) begin
          lat  = n;
          data = v.is_ex ? ex_rdata_out : if_data_out;
        end
        ex_req_in = 1'b0;
        if_req_in = 1'b0;
      end
      if (v.is_ex ? if_ready_out : ex_ready_out) wrong++;
    end
    ex_req_in = 1'b0;
    if_req_in = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_pulses", idx), pulses, 1);
    chk($sformatf("v%0d_other_pulses", idx), wrong, 0);
    chk($sformatf("v%0d_data", idx), data, v.exp_data);
    chk($sformatf("v%0d_rd_addr", idx), rd_addr, v.exp_addr);
    chk($sformatf("v%0d_writes", idx), wr_cnt, v.rw ? 1 : 0);
    if (v.rw) begin
      chk($sformatf("v%0d_wr_addr", idx), wr_addr, v.exp_addr);
      chk($sformatf("v%0d_wr_data", idx), wr_data, v.wdata);
    end
    chk1($sformatf("v%0d_hold", idx), hold_ok, 1'b1);
  endtask

  initial begin
    int          lat;
    int          if_lat;
    int          pulses;
    int          ex_pulses;
    int          cnt_req;
    logic [31:0] ex_data;
    logic [31:0] fetch_data;
    logic [31:0] fetch_addr;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0103, 32'hDEAD_BEEF, 32'h0, 0,
                32'h0000_0100, 32'hDEAD_BEEF, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0101, 32'h1122_3344,
                sb_merge(32'h1122_3344, 2'd1, 8'hAA), 0,
                32'h0000_0100, 32'h1122_3344, 4};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0000_0013, 32'h0, 0,
                32'h0000_0080, 32'h0000_0013, 2};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0BAD_F00D, 32'h0, 2,
                32'h0000_2000, 32'h0BAD_F00D, 4};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h1234_5678, 1,
                32'h0000_0044, 32'hCAFE_F00D, 6};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'h55AA_55AA, 32'h0, 1,
                32'hFFFF_FFFC, 32'h55AA_55AA, 3};

    // Reset state, with an EX request pending to show hold is masked.
    ex_req_in = 1'b1;
    repeat (3) sample();
    chk1("reset_hold", hold_flag_out, 1'b0);
    chk("reset_ctrl", 32'({mem_req_out, mem_we_out, if_ready_out, ex_ready_out, bus_err_out}), 32'h0);
    chk("reset_data", mem_addr_out | mem_data_out | if_data_out | ex_rdata_out, 32'h0);
    rst = 1'b0;
    ex_req_in = 1'b0;
    sample();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
      if (i == 2) chk("ex_rdata_kept_over_fetch", ex_rdata_out, 32'h1122_3344);
    end

    // Simultaneous requests: EX first, then fetch.
    rd_word = 32'hA5A5_A5A5; ack_delay = 0;
    ex_req_in = 1'b1; ex_rw_in = 1'b0; ex_addr_in = 32'h200;
    if_req_in = 1'b1; if_addr_in = 32'h80;
    lat = 0; if_lat = 0; pulses = 0; ex_pulses = 0;
    ex_data = '0; fetch_data = '0; fetch_addr = '0;
    for (int n = 1; n <= 12; n++) begin
      sample();
      if (mem_req_out && mem_ack_in && (lat != 0)) fetch_addr = mem_addr_out;
      if (ex_ready_out) begin
        ex_pulses++;
        if (lat == 0) begin lat = n; ex_data = ex_rdata_out; end
        ex_req_in = 1'b0;
        rd_word   = 32'h0000_0013;
      end
      if (if_ready_out) begin
        pulses++;
        if (if_lat == 0) begin if_lat = n; fetch_data = if_data_out; end
        if_req_in = 1'b0;
      end
    end
    ex_req_in = 1'b0; if_req_in = 1'b0;
    chk("arb_ex_latency", lat, 2);
    chk("arb_ex_pulses", ex_pulses, 1);
    chk("arb_ex_data", ex_data, 32'hA5A5_A5A5);
    chk("arb_if_latency", if_lat, 5);
    chk("arb_if_pulses", pulses, 1);
    chk("arb_if_data", fetch_data, 32'h0000_0013);
    chk("arb_if_addr", fetch_addr, 32'h0000_0080);

    // Flush while a fetch waits for a late ack.
    rd_word = 32'h0000_0099; ack_delay = 2;
    if_req_in = 1'b1; if_addr_in = 32'h300;
    cnt_req = 0; pulses = 0;
    for (int n = 1; n <= 8; n++) begin
      sample();
      if (mem_req_out) cnt_req++;
      if (if_ready_out) pulses++;
      if (n == 1) begin if_flush_in = 1'b1; if_req_in = 1'b0; end
      if (n == 2) if_flush_in = 1'b0;
    end
    chk("flush_bus_cycles", cnt_req, 3);
    chk("flush_no_pulse", pulses, 0);
    chk1("flush_back_idle", mem_req_out, 1'b0);

    // Read that is never acknowledged.
    rd_word = 32'h0000_0005; ack_delay = -1;
    ex_req_in = 1'b1; ex_rw_in = 1'b0; ex_addr_in = 32'h400;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      sample();
      if (n == 4) begin
        chk1("to_err_before", bus_err_out, 1'b0);
        chk1("to_hold_waiting", hold_flag_out, 1'b1);
      end
      if (ex_ready_out && (lat == 0)) begin
        lat = n;
        chk1("to_err_set", bus_err_out, 1'b1);
        chk("to_rdata_zero", ex_rdata_out, 32'h0);
        chk1("to_hold_released", hold_flag_out, 1'b0);
        ex_req_in = 1'b0;
      end
    end
    ex_req_in = 1'b0;
    chk("to_latency", lat, 5);
    chk1("to_err_sticky", bus_err_out, 1'b1);

    // Reset arriving while the write phase of a store is outstanding.
    rd_word = 32'h0000_0001; ack_delay = 0;
    ex_req_in = 1'b1; ex_rw_in = 1'b1; ex_addr_in = 32'h500; ex_wdata_in = 32'h77;
    sample();
    sample();
    ack_delay = -1;
    sample();
    chk("wr_phase_ctrl", 32'({mem_req_out, mem_we_out}), 32'h3);
    chk("wr_phase_addr", mem_addr_out, 32'h500);
    chk("wr_phase_data", mem_data_out, 32'h77);
    rst = 1'b1;
    sample();
    chk("rst_ctrl", 32'({mem_req_out, mem_we_out, if_ready_out, ex_ready_out, hold_flag_out}), 32'h0);
    chk1("rst_bus_err", bus_err_out, 1'b0);
    chk("rst_data", mem_addr_out | mem_data_out | if_data_out | ex_rdata_out, 32'h0);
    rst = 1'b0; ex_req_in = 1'b0; ack_delay = 0;
    sample();
    chk1("rst_idle", mem_req_out, 1'b0);
    sample();
    run_vec(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
